// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one 32x32 Wallace-tree multiplier between two requesters.
//   clk, rst                 : clock, asynchronous active-high reset
//   req{0,1}_valid/_a/_b     : operand pair offered by each requester
//   req{0,1}_ready           : combinational grant; handshake completes on valid && ready
//   res_valid/res_tag/res_prod/res_ready : result register and its consumer handshake
//   busy                     : high whenever the FSM is not IDLE
// MUL_CYCLES (1..15) is the number of edges operands sit on the multiplier before capture.

// Pure combinational 32x32 unsigned multiplier, partial products reduced by a
// Wallace tree of 3:2 carry-save layers down to two rows, then one final adder.
module wallace_mul32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    localparam int unsigned ROWS = 32;

    function automatic logic [63:0] wallace(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] cur [ROWS];
        logic [63:0] nxt [ROWS];
        int n;
        int m;
        int base;
        for (int i = 0; i < 32; i++) begin
            cur[i] = y[i] ? (64'(x) << i) : 64'd0;
        end
        n = 32;
        // 32->22->15->10->7->5->4->3->2 rows takes eight layers
        for (int l = 0; l < 8; l++) begin
            m = 0;
            for (int i = 0; i < 32; i++) begin
                nxt[i] = 64'd0;
            end
            for (int g = 0; g < 11; g++) begin
                if (3 * g + 2 < n) begin
                    nxt[m]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                    nxt[m + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2])
                                 | (cur[3*g+1] & cur[3*g+2])) << 1;
                    m = m + 2;
                end
            end
            // rows that did not fill a group of three pass through unchanged
            base = 3 * (n / 3);
            for (int i = 0; i < 32; i++) begin
                if (i >= base && i < n) begin
                    nxt[m] = cur[i];
                    m = m + 1;
                end
            end
            cur = nxt;
            n   = m;
        end
        return cur[0] + cur[1];
    endfunction

    assign p = wallace(a, b);
endmodule

module mul_arbiter #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    output logic        res_tag,
    output logic [63:0] res_prod,
    input  logic        res_ready,
    output logic        busy
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic              ptr;
    logic [31:0]       op_a, op_b;
    logic              op_tag;
    logic [63:0]       mul_p;
    logic              grant0_c, grant1_c;
    logic              accept0_c, accept1_c, dec_c, capture_c, retire_c;

    // Lone requester always wins; on contention the pointer picks (0 -> req0)
    assign grant0_c = req0_valid && (!req1_valid || !ptr);
    assign grant1_c = req1_valid && (!req0_valid ||  ptr);

    // Multiplier sees only the operand registers
    wallace_mul32 u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state and control strobes
    always_comb begin
        state_d    = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept0_c  = 1'b0;
        accept1_c  = 1'b0;
        dec_c      = 1'b0;
        capture_c  = 1'b0;
        retire_c   = 1'b0;
        case (state)
            IDLE: begin
                // readys are forced low while reset is held
                req0_ready = grant0_c && !rst;
                req1_ready = grant1_c && !rst;
                accept0_c  = req0_valid && req0_ready;
                accept1_c  = req1_valid && req1_ready;
                if (accept0_c || accept1_c) state_d = CALC;
            end
            CALC: begin
                if (cnt == '0) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end else begin
                    dec_c = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    retire_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, counter, pointer and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_tag    <= 1'b0;
            cnt       <= '0;
            ptr       <= 1'b0;
            res_valid <= 1'b0;
            res_tag   <= 1'b0;
            res_prod  <= '0;
        end else begin
            if (accept0_c) begin
                op_a   <= req0_a;
                op_b   <= req0_b;
                op_tag <= 1'b0;
                cnt    <= CNT_W'(MUL_CYCLES - 1);
            end else if (accept1_c) begin
                op_a   <= req1_a;
                op_b   <= req1_b;
                op_tag <= 1'b1;
                cnt    <= CNT_W'(MUL_CYCLES - 1);
            end
            if (dec_c) cnt <= cnt - CNT_W'(1);
            if (capture_c) begin
                res_prod  <= mul_p;
                res_tag   <= op_tag;
                res_valid <= 1'b1;
            end
            if (retire_c) begin
                res_valid <= 1'b0;
                ptr       <= ~res_tag;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: main instance at MUL_CYCLES=2, plus
// MUL_CYCLES=1 and 15 instances driven in lockstep for the latency sweep.
module tb_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_tag, res_ready, busy;
    logic [63:0] res_prod;

    logic        s_valid, s_res_ready;
    logic [31:0] s_a, s_b;
    logic        s1_r0, s1_r1, s1_valid, s1_tag, s1_busy;
    logic        s15_r0, s15_r1, s15_valid, s15_tag, s15_busy;
    logic [63:0] s1_prod, s15_prod;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_tag(res_tag), .res_prod(res_prod),
        .res_ready(res_ready), .busy(busy)
    );

    mul_arbiter #(.MUL_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .req0_valid(s_valid), .req0_a(s_a), .req0_b(s_b), .req0_ready(s1_r0),
        .req1_valid(1'b0), .req1_a(32'd0), .req1_b(32'd0), .req1_ready(s1_r1),
        .res_valid(s1_valid), .res_tag(s1_tag), .res_prod(s1_prod),
        .res_ready(s_res_ready), .busy(s1_busy)
    );

    mul_arbiter #(.MUL_CYCLES(15)) dut_s15 (
        .clk(clk), .rst(rst),
        .req0_valid(s_valid), .req0_a(s_a), .req0_b(s_b), .req0_ready(s15_r0),
        .req1_valid(1'b0), .req1_a(32'd0), .req1_b(32'd0), .req1_ready(s15_r1),
        .res_valid(s15_valid), .res_tag(s15_tag), .res_prod(s15_prod),
        .res_ready(s_res_ready), .busy(s15_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 2 time units after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int lat1, lat15;
        logic [63:0] hold_prod;

        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0;
        s_valid = 1'b0; s_a = 32'd0; s_b = 32'd0; s_res_ready = 1'b0;

        // reset state, readys gated even with both valids high
        #3;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tag",   res_tag,   0);
        chk("rst_res_prod",  res_prod,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_ready0",    req0_ready, 0);
        chk("rst_ready1",    req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst = 1'b0;

        // basic: req0 3*5
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
        #1;
        chk("basic_ready0", req0_ready, 1);
        chk("basic_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("basic_busy",      busy,       1);
        chk("basic_calc_rdy0", req0_ready, 0);
        chk("basic_e0_valid",  res_valid,  0);
        step();
        chk("basic_e1_valid", res_valid, 0);
        step();
        chk("basic_e2_valid", res_valid, 1);
        chk("basic_prod",     res_prod,  64'd15);
        chk("basic_tag",      res_tag,   0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("basic_retire_valid", res_valid, 0);
        chk("basic_retire_busy",  busy,      0);

        // max operands on req1
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
        #1;
        chk("max_ready1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        step(); step();
        chk("max_valid", res_valid, 1);
        chk("max_prod",  res_prod,  64'hFFFF_FFFE_0000_0001);
        chk("max_tag",   res_tag,   1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // arbitration after a fresh reset (pointer back to 0)
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd7;
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd9;
        #1;
        chk("arb1_ready0", req0_ready, 1);
        chk("arb1_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("arb1_calc_ready1", req1_ready, 0);
        step(); step();
        chk("arb1_prod", res_prod, 64'd14);
        chk("arb1_tag",  res_tag,  0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("arb2_ready0", req0_ready, 0);
        chk("arb2_ready1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        step(); step();
        chk("arb2_prod", res_prod, 64'd36);
        chk("arb2_tag",  res_tag,  1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("arb3_ready0", req0_ready, 1);
        chk("arb3_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        step(); step();
        chk("arb3_prod", res_prod, 64'd14);
        chk("arb3_tag",  res_tag,  0);

        // backpressure: hold DONE five cycles while req1 keeps asking
        hold_prod = res_prod;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid",  res_valid,  1);
            chk("bp_prod",   res_prod,   hold_prod);
            chk("bp_tag",    res_tag,    0);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_busy",  busy,      0);
        chk("bp_release_ready1", req1_ready, 1);
        req1_valid = 1'b0;

        // asynchronous reset in CALC
        step();
        req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd7;
        step();
        req0_valid = 1'b0;
        #1;
        chk("abort_calc_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy",   busy,      0);
        chk("abort_valid",  res_valid, 0);
        chk("abort_prod",   res_prod,  0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_result", res_valid, 0);
        end
        req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd13;
        #1;
        chk("post_abort_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        step(); step();
        chk("post_abort_valid", res_valid, 1);
        chk("post_abort_prod",  res_prod,  64'd143);
        chk("post_abort_tag",   res_tag,   0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // latency sweep MUL_CYCLES=1 and 15
        s_valid = 1'b1; s_a = 32'h1234_5678; s_b = 32'h9ABC_DEF0;
        #1;
        chk("sweep_ready_1",  s1_r0,  1);
        chk("sweep_ready_15", s15_r0, 1);
        step();
        s_valid = 1'b0;
        lat1 = -1; lat15 = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lat1  < 0 && s1_valid)  lat1  = k;
            if (lat15 < 0 && s15_valid) lat15 = k;
        end
        chk("sweep_lat_1",   64'(lat1),  64'd1);
        chk("sweep_lat_15",  64'(lat15), 64'd15);
        chk("sweep_prod_1",  s1_prod,  64'h0B00_EA4E_242D_2080);
        chk("sweep_prod_15", s15_prod, 64'h0B00_EA4E_242D_2080);
        s_res_ready = 1'b1;
        step();
        s_res_ready = 1'b0;
        chk("sweep_retire_1",  s1_busy,  0);
        chk("sweep_retire_15", s15_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
